// File: rtl/alu_operand_pkg.sv
// Shared constants for the ALU operand-select stage: source indices,
// the hard-wired zero register and the bypass tag encoding.
package alu_operand_pkg;

   localparam int SRC_REG   = 0;
   localparam int SRC_SHIFT = 1;
   localparam int SRC_IMM   = 2;
   localparam int SRC_PC    = 3;

   localparam int ZERO_REG  = 0;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_EX   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_tag_e;

endpackage

// File: rtl/alu_fwd_unit.sv
// Combinational EX/MEM bypass compare and load-use hazard detect for the
// register source. Bypass logic exists only when ALU_OPERAND_FWD_EN is defined.
module alu_fwd_unit
   import alu_operand_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  src_is_reg,
   input  logic [REG_ADDR_W-1:0] rs_addr,
   input  logic [DATA_W-1:0]     reg_data,
   input  logic                  ex_wr_en,
   input  logic [REG_ADDR_W-1:0] ex_wr_addr,
   input  logic [DATA_W-1:0]     ex_wr_data,
   input  logic                  ex_is_load,
   input  logic                  mem_wr_en,
   input  logic [REG_ADDR_W-1:0] mem_wr_addr,
   input  logic [DATA_W-1:0]     mem_wr_data,
   output logic [DATA_W-1:0]     fwd_data,
   output fwd_tag_e              fwd_tag,
   output logic                  hazard
);

`ifdef ALU_OPERAND_FWD_EN
   logic bypass_ok;
   logic ex_hit;
   logic mem_hit;

   // r0 is hard-wired zero, so a pending write to it must never be bypassed.
   assign bypass_ok = src_is_reg && (rs_addr != REG_ADDR_W'(ZERO_REG));
   assign ex_hit    = bypass_ok && ex_wr_en  && (ex_wr_addr  == rs_addr);
   assign mem_hit   = bypass_ok && mem_wr_en && (mem_wr_addr == rs_addr);

   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      fwd_data = reg_data;
      fwd_tag  = FWD_NONE;
      if (ex_hit) begin
         fwd_data = ex_wr_data;
         fwd_tag  = FWD_EX;
      end else if (mem_hit) begin
         fwd_data = mem_wr_data;
         fwd_tag  = FWD_MEM;
      end
   end

   // A load in EX has no data yet; an older MEM match is stale, so stall anyway.
   assign hazard = ex_hit && ex_is_load;
`else
   logic unused_fwd;

   assign fwd_data   = reg_data;
   assign fwd_tag    = FWD_NONE;
   assign hazard     = 1'b0;
   assign unused_fwd = ^{src_is_reg, rs_addr, ex_wr_en, ex_wr_addr, ex_wr_data,
                         ex_is_load, mem_wr_en, mem_wr_addr, mem_wr_data};
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand-select stage for one ALU input: source mux, optional
// EX/MEM bypass (ALU_OPERAND_FWD_EN), one-deep valid/ready register, stall counter.
module alu_operand_stage
   import alu_operand_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int NUM_SRC    = 4,
   parameter int REG_ADDR_W = 5,
   parameter int SEL_W      = $clog2(NUM_SRC)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
   input  logic [SEL_W-1:0]          src_sel_i,
   input  logic [REG_ADDR_W-1:0]     rs_addr_i,
   input  logic                      ex_wr_en_i,
   input  logic [REG_ADDR_W-1:0]     ex_wr_addr_i,
   input  logic [DATA_W-1:0]         ex_wr_data_i,
   input  logic                      ex_is_load_i,
   input  logic                      mem_wr_en_i,
   input  logic [REG_ADDR_W-1:0]     mem_wr_addr_i,
   input  logic [DATA_W-1:0]         mem_wr_data_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [DATA_W-1:0]         data_o,
   output logic [1:0]                fwd_o,
   output logic [15:0]               stall_cnt_o
);

   logic              src_is_reg;
   logic [DATA_W-1:0] sel_data;
   logic [DATA_W-1:0] fwd_data;
   fwd_tag_e          fwd_tag;
   logic              hazard;
   logic [DATA_W-1:0] next_data;
   logic [1:0]        next_tag;
   logic              accept;

   assign src_is_reg = (src_sel_i == SEL_W'(SRC_REG));

   // Out-of-range selects fall through to the zero default.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (src_sel_i == SEL_W'(k)) sel_data = src_data_i[k*DATA_W +: DATA_W];
      end
   end

   alu_fwd_unit #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd (
      .src_is_reg  (src_is_reg),
      .rs_addr     (rs_addr_i),
      .reg_data    (src_data_i[DATA_W-1:0]),
      .ex_wr_en    (ex_wr_en_i),
      .ex_wr_addr  (ex_wr_addr_i),
      .ex_wr_data  (ex_wr_data_i),
      .ex_is_load  (ex_is_load_i),
      .mem_wr_en   (mem_wr_en_i),
      .mem_wr_addr (mem_wr_addr_i),
      .mem_wr_data (mem_wr_data_i),
      .fwd_data    (fwd_data),
      .fwd_tag     (fwd_tag),
      .hazard      (hazard)
   );

   assign next_data  = src_is_reg ? fwd_data : sel_data;
   assign next_tag   = src_is_reg ? fwd_tag  : FWD_NONE;

   assign in_ready_o = (!out_valid_o || out_ready_i) && !hazard;
   assign accept     = in_valid_i && in_ready_o;

   // NOTE: reset is synchronous and checked first, so it wins over a same-cycle accept.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_o <= 1'b0;
         data_o      <= '0;
         fwd_o       <= FWD_NONE;
      end else if (accept) begin
         out_valid_o <= 1'b1;
         data_o      <= next_data;
         fwd_o       <= next_tag;
      end else if (out_ready_i) begin
         out_valid_o <= 1'b0;
      end
   end

`ifdef ALU_OPERAND_FWD_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
      end else if (in_valid_i && hazard && (stall_cnt_o != 16'hFFFF)) begin
         stall_cnt_o <= stall_cnt_o + 16'd1;
      end
   end
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage (NUM_SRC=3): directed scenarios
// plus randomized traffic against a cycle-level reference model.
module tb_alu_operand_stage;

   localparam int DATA_W     = 32;
   localparam int NUM_SRC    = 3;
   localparam int REG_ADDR_W = 5;
   localparam int SEL_W      = $clog2(NUM_SRC);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      rst;
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_W-1:0]         src [NUM_SRC];
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [SEL_W-1:0]          sel;
   logic [REG_ADDR_W-1:0]     rs;
   logic                      ex_en, ex_load, mem_en;
   logic [REG_ADDR_W-1:0]     ex_addr, mem_addr;
   logic [DATA_W-1:0]         ex_data, mem_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         data;
   logic [1:0]                fwd;
   logic [15:0]               stall_cnt;

   assign src_data = {src[2], src[1], src[0]};

   alu_operand_stage #(
      .DATA_W     (DATA_W),
      .NUM_SRC    (NUM_SRC),
      .REG_ADDR_W (REG_ADDR_W)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .src_data_i    (src_data),
      .src_sel_i     (sel),
      .rs_addr_i     (rs),
      .ex_wr_en_i    (ex_en),
      .ex_wr_addr_i  (ex_addr),
      .ex_wr_data_i  (ex_data),
      .ex_is_load_i  (ex_load),
      .mem_wr_en_i   (mem_en),
      .mem_wr_addr_i (mem_addr),
      .mem_wr_data_i (mem_data),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .data_o        (data),
      .fwd_o         (fwd),
      .stall_cnt_o   (stall_cnt)
   );

   // Reference state: what the ALU should currently be seeing.
   logic        m_valid;
   logic [31:0] m_data;
   logic [1:0]  m_tag;
   int          m_cnt;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Operand the ALU should receive for the current request, from the rules directly.
   function automatic void ref_operand(output logic [31:0] d, output logic [1:0] t,
                                       output logic hz);
      int s;
      s  = int'(sel);
      d  = (s < NUM_SRC) ? src[s] : 32'h0;
      t  = 2'b00;
      hz = 1'b0;
`ifdef ALU_OPERAND_FWD_EN
      if (s == 0 && rs != 0) begin
         if (ex_en && ex_addr == rs) begin
            d  = ex_data;
            t  = 2'b01;
            hz = ex_load;
         end else if (mem_en && mem_addr == rs) begin
            d = mem_data;
            t = 2'b10;
         end
      end
`endif
   endfunction

   // One clock: check in_ready before the edge, advance model, check outputs after.
   task automatic cycle();
      logic [31:0] d;
      logic [1:0]  t;
      logic        hz, rdy;
      #1;
      ref_operand(d, t, hz);
      rdy = (!m_valid || out_ready) && !hz;
      check("in_ready", {63'd0, in_ready}, {63'd0, rdy});
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_tag   = '0;
         m_cnt   = 0;
      end else begin
         if (in_valid && hz && m_cnt < 65535) m_cnt++;
         if (in_valid && rdy) begin
            m_valid = 1'b1;
            m_data  = d;
            m_tag   = t;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
      end
      #1;
      check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      check("data",      {32'd0, data},      {32'd0, m_data});
      check("fwd",       {62'd0, fwd},       {62'd0, m_tag});
      check("stall_cnt", {48'd0, stall_cnt}, 64'(m_cnt));
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      sel       = '0;
      rs        = '0;
      ex_en     = 1'b0;
      ex_load   = 1'b0;
      ex_addr   = '0;
      ex_data   = '0;
      mem_en    = 1'b0;
      mem_addr  = '0;
      mem_data  = '0;
      for (int k = 0; k < NUM_SRC; k++) src[k] = '0;
   endtask

   initial begin
      m_valid = 1'b0;
      m_data  = '0;
      m_tag   = '0;
      m_cnt   = 0;
      idle_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      cycle();
      cycle();
      check("reset_valid", {63'd0, out_valid}, 64'd0);
      check("reset_data",  {32'd0, data},      64'd0);
      rst = 1'b0;

      // Plain select of source 1.
      in_valid = 1'b1;
      sel      = SEL_W'(1);
      src[1]   = 32'h0000_001F;
      cycle();
      check("plain_data",  {32'd0, data},      64'h1F);
      check("plain_fwd",   {62'd0, fwd},       64'd0);
      check("plain_valid", {63'd0, out_valid}, 64'd1);

      // EX beats MEM when both target rs.
      sel      = '0;
      rs       = 5'd5;
      src[0]   = 32'h1111_1111;
      ex_en    = 1'b1; ex_addr  = 5'd5; ex_data  = 32'hAAAA_0000;
      mem_en   = 1'b1; mem_addr = 5'd5; mem_data = 32'h5555_0000;
      cycle();
`ifdef ALU_OPERAND_FWD_EN
      check("ex_prio_data", {32'd0, data}, 64'hAAAA_0000);
      check("ex_prio_fwd",  {62'd0, fwd},  64'd1);
`else
      check("ex_prio_data", {32'd0, data}, 64'h1111_1111);
      check("ex_prio_fwd",  {62'd0, fwd},  64'd0);
`endif

      // Writes to r0 are never bypassed.
      rs      = '0;
      src[0]  = '0;
      ex_addr = '0;
      ex_data = 32'hDEAD_BEEF;
      mem_en  = 1'b0;
      cycle();
      check("r0_data", {32'd0, data}, 64'd0);
      check("r0_fwd",  {62'd0, fwd},  64'd0);

      // Load-use: EX load to r7 held 3 cycles, then cleared.
      rst = 1'b1;
      cycle();
      rst     = 1'b0;
      rs      = 5'd7;
      src[0]  = 32'h0000_0777;
      ex_en   = 1'b1; ex_addr = 5'd7; ex_load = 1'b1; ex_data = 32'h7070_7070;
      for (int i = 0; i < 3; i++) cycle();
`ifdef ALU_OPERAND_FWD_EN
      check("lu_cnt", {48'd0, stall_cnt}, 64'd3);
`else
      check("lu_cnt", {48'd0, stall_cnt}, 64'd0);
`endif
      ex_en   = 1'b0;
      ex_load = 1'b0;
      cycle();
      check("lu_accept_valid", {63'd0, out_valid}, 64'd1);
      check("lu_accept_data",  {32'd0, data},      64'h777);

      // Backpressure, then same-cycle drain and accept.
      sel    = SEL_W'(1);
      src[1] = 32'h0000_CAFE;
      cycle();
      out_ready = 1'b0;
      src[1]    = 32'h0000_1234;
      cycle();
      check("bp_hold_data", {32'd0, data},     64'hCAFE);
      check("bp_ready",     {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      cycle();
      check("bp_new_data",  {32'd0, data},      64'h1234);
      check("bp_valid",     {63'd0, out_valid}, 64'd1);

      // Reset discards a held operand even with a request present.
      rst = 1'b1;
      cycle();
      check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
      rst = 1'b0;

      // Out-of-range select yields zero.
      sel    = SEL_W'(NUM_SRC);
      src[0] = 32'h0101_0101;
      src[1] = 32'h0202_0202;
      src[2] = 32'h0303_0303;
      cycle();
      check("range_data",  {32'd0, data},      64'd0);
      check("range_fwd",   {62'd0, fwd},       64'd0);
      check("range_valid", {63'd0, out_valid}, 64'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 49) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         sel       = SEL_W'($urandom_range(0, 3));
         rs        = REG_ADDR_W'($urandom_range(0, 7));
         for (int k = 0; k < NUM_SRC; k++) src[k] = $urandom;
         ex_en     = $urandom_range(0, 1) == 1;
         ex_addr   = REG_ADDR_W'($urandom_range(0, 7));
         ex_data   = $urandom;
         ex_load   = ($urandom_range(0, 3) == 0);
         mem_en    = $urandom_range(0, 1) == 1;
         mem_addr  = REG_ADDR_W'($urandom_range(0, 7));
         mem_data  = $urandom;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
